decoder_2to4: RTL and testbench

Registered binary-to-one-hot decoder. A 2-bit select code on `x` drives exactly one bit of the 4-bit output `y` high, captured on the rising clock edge. The block sits behind the `deco_if` interface and is driven by the `base_test` stimulus environment. Width is parameterized; the default configuration is the 2-to-4 decoder.

---
 rtl/decoder_2to4_if.sv | 23 ++
 rtl/decoder_2to4.sv | 55 +++++
 tb/tb_decoder_2to4.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/decoder_2to4_if.sv
// deco_if: bundles the select code, the one-hot decode and its valid flag.
// The stimulus side (master) drives the code. The decoder (slave) returns
// the registered decode.
interface deco_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 1 << IN_W
);
  logic [IN_W-1:0]  in;     // binary select code
  logic [OUT_W-1:0] out;    // registered one-hot decode
  logic             valid;  // high from the first post-reset clock edge

  modport master (
    output in,
    input  out,
    input  valid
  );

  modport slave (
    input  in,
    output out,
    output valid
  );
endinterface

// File: rtl/decoder_2to4.sv
// decoder_2to4: registered binary-to-one-hot decoder with an asynchronous,
// active-low reset. The output register loads 1 << code on every rising
// clock edge. A valid flag rises at the first edge after reset is released.
module decoder_2to4 #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic  clk,
  input  logic  reset,
  deco_if.slave bus
);

  // A one-hot output only makes sense when every code has its own bit.
  if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
    $error("decoder_2to4: IN_W=%0d outside 1..8", IN_W);
  end
  if (OUT_W != (1 << IN_W)) begin : g_bad_out_w
    $error("decoder_2to4: OUT_W=%0d must equal 2**IN_W=%0d", OUT_W, 1 << IN_W);
  end

  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;
  logic             vld_q;

  // Equality compare per bit, not a shift. An unknown code then matches no
  // bit, and the output registers all zeros instead of propagating X.
  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (code == IN_W'(i)) onehot[i] = 1'b1;
    end
    return onehot;
  endfunction

  // Next output value: pure decode of the code presented this cycle.
  always_comb begin
    y_d = decode(bus.in);
  end

  // Output register. Reset clears it immediately; otherwise it loads the decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= 1'b1;
    end
  end

  assign bus.out   = y_q;
  assign bus.valid = vld_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// Testbench for decoder_2to4. The stimulus process drives codes on the
// falling edge and queues the hand-computed decode for each code. The
// monitor process samples just after each rising edge and compares every
// valid output against the queue head. Asynchronous-reset and mid-cycle
// behaviour is compared directly at the exact instants involved.
module tb_decoder_2to4;

  logic clk;
  logic reset;

  deco_if #(.IN_W(2)) bus ();

  decoder_2to4 #(.IN_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b1;

  // Hand-computed decode table for codes 0..3.
  logic [3:0] dec_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a code on the falling edge and queue the decode that the next
  // rising edge must produce.
  task automatic drive(input int v);
    @(negedge clk);
    bus.in = 2'(v);
    exp_q.push_back(dec_tab[v]);
  endtask

  // Monitor: after every rising edge, a valid output must match the queue head.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("decode", 32'(bus.out), 32'(e));
          check("onehot", 32'($onehot(bus.out)), 32'd1);
        end
      end
    end
  end

  // Watchdog: the run ends long before this fires.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in = '0;
    reset  = 1'b0;

    // Reset held for 5 cycles while the code toggles: outputs stay cleared.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in = 2'(i % 4);
      @(posedge clk);
      #1;
      check("reset_y", 32'(bus.out), 32'h0);
      check("reset_valid", 32'(bus.valid), 32'h0);
    end

    // Release reset together with the first code.
    @(negedge clk);
    reset  = 1'b1;
    bus.in = 2'd0;
    exp_q.push_back(4'b0001);
    #1;
    check("release_before_edge_y", 32'(bus.out), 32'h0);
    @(posedge clk);
    #1;
    check("release_valid", 32'(bus.valid), 32'h1);

    // Exhaustive decode, consecutive cycles (code 0 was already applied).
    drive(1);
    drive(2);
    drive(3);

    // Glitch test: register code 1, then wiggle the code between edges.
    drive(1);
    @(negedge clk);
    bus.in = 2'd3;
    #2;
    bus.in = 2'd2;
    exp_q.push_back(4'b0100);
    #1;
    check("glitch_hold_y", 32'(bus.out), 32'b0010);

    // Hold code 2 for 10 cycles.
    for (int i = 0; i < 10; i++) drive(2);

    // Mid-operation reset: y=1000, then reset drops while clock is high.
    drive(3);
    @(posedge clk);
    #3;
    check("pre_reset_y", 32'(bus.out), 32'b1000);
    reset = 1'b0;
    #1;
    check("async_reset_y", 32'(bus.out), 32'h0);
    check("async_reset_valid", 32'(bus.valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_y", 32'(bus.out), 32'h0);

    // Release reset with code 1. Output stays 0 until the next rising edge.
    @(negedge clk);
    reset  = 1'b1;
    bus.in = 2'd1;
    exp_q.push_back(4'b0010);
    #2;
    check("rerelease_before_edge_y", 32'(bus.out), 32'h0);

    // Randomized run against y(N+1) = 1 << x(N).
    for (int i = 0; i < 1000; i++) drive(int'($urandom_range(0, 3)));

    // Let the last queued decode be compared, then park in reset.
    @(posedge clk);
    #2;
    reset  = 1'b0;
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    #1;
    check("final_reset_y", 32'(bus.out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
